// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine for the EX stage.
// One bit per cycle: shift-add multiply (LSB first), restoring divide (MSB first).
// Returns {hi, lo}: the full product for multiplies, {remainder, quotient} for divides.
// Op encoding on op_i: 00 mult, 01 multu, 10 div, 11 divu (bit1 = divide, bit0 = unsigned).
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;

  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [DW-1:0]    r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_ready;
  logic [DW-1:0]    r_result;
  logic             r_dbz;

  logic             w_op_div;
  logic             w_op_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sum;
  logic [DW-1:0]    w_acc_nxt;

  logic [WIDTH:0]   w_shift;
  logic             w_qbit;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  logic [DW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [DW-1:0]    w_result;

  // Operand decode: signs and magnitudes (magnitudes are unsigned, so -2^(W-1) is exact)
  always_comb begin
    w_op_div    = op_i[1];
    w_op_signed = ~op_i[0];
    w_sa        = w_op_signed & opdata1_i[WIDTH-1];
    w_sb        = w_op_signed & opdata2_i[WIDTH-1];
    w_mag1      = w_sa ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    w_mag2      = w_sb ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    w_accept    = (r_state == S_IDLE) & start_i & ~annul_i;
    w_div_zero  = w_op_div & (opdata2_i == '0);
    w_last      = (r_state == S_CALC) & (r_cnt == CNT_W'(1));
  end

  // One iteration step for both operations plus the sign fix-up of the final step
  always_comb begin
    // multiply: lo half of the accumulator holds the multiplier and is retired LSB first
    w_add     = r_acc[0] ? {1'b0, r_a} : '0;
    w_sum     = {1'b0, r_acc[DW-1:WIDTH]} + w_add;
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // restoring divide: WIDTH+1-bit partial remainder, dividend shifted out MSB first
    w_shift   = {r_rem, r_a[WIDTH-1]};
    w_qbit    = (w_shift >= {1'b0, r_b});
    w_diff    = WIDTH'(w_shift - {1'b0, r_b});
    w_rem_nxt = w_qbit ? w_diff : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_a[WIDTH-2:0], w_qbit};

    w_prod_fix = r_neg_res ? (~w_acc_nxt + DW'(1)) : w_acc_nxt;
    w_quo_fix  = r_neg_res ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
    w_rem_fix  = r_neg_rem ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;
    w_result   = r_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; an annul sampled on the final CALC edge skips DONE entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (annul_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, iteration counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_ready <= (w_next == S_DONE);
      if (w_accept) begin
        r_is_div  <= w_op_div;
        r_neg_res <= w_sa ^ w_sb;
        r_neg_rem <= w_sa;
        r_a       <= w_mag1;
        r_b       <= w_mag2;
        r_acc     <= {WIDTH'(0), w_mag2};
        r_rem     <= '0;
        r_cnt     <= CNT_W'(WIDTH);
        if (w_div_zero) begin
          r_result <= {opdata1_i, {WIDTH{1'b1}}};
          r_dbz    <= 1'b1;
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_is_div) begin
          r_a   <= w_quo_nxt;
          r_rem <= w_rem_nxt;
        end else begin
          r_acc <= w_acc_nxt;
        end
        if (w_last && !annul_i) begin
          r_result <= w_result;
          r_dbz    <= 1'b0;
        end
      end
    end
  end

  assign busy_o        = r_busy;
  assign ready_o       = r_ready;
  assign result_o      = r_result;
  assign div_by_zero_o = r_dbz;

endmodule
